// File: rtl/pacman_pkg.sv
// Shared types and PS/2 set-2 scan-code constants for the pacman direction decoder.
package pacman_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_EXT,
        PS_BRK,
        PS_EXT_BRK
    } prefix_state_t;

    typedef struct packed {
        logic hit;
        dir_t dir;
    } key_hit_t;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;

    function automatic key_hit_t arrow_lookup(input logic [7:0] code);
        key_hit_t k;
        k = '0;
        case (code)
            SC_UP:    k = '{hit: 1'b1, dir: DIR_UP};
            SC_DOWN:  k = '{hit: 1'b1, dir: DIR_DOWN};
            SC_LEFT:  k = '{hit: 1'b1, dir: DIR_LEFT};
            SC_RIGHT: k = '{hit: 1'b1, dir: DIR_RIGHT};
            default:  k = '0;
        endcase
        return k;
    endfunction

    function automatic key_hit_t wasd_lookup(input logic [7:0] code);
        key_hit_t k;
        k = '0;
        case (code)
            SC_W:    k = '{hit: 1'b1, dir: DIR_UP};
            SC_S:    k = '{hit: 1'b1, dir: DIR_DOWN};
            SC_A:    k = '{hit: 1'b1, dir: DIR_LEFT};
            SC_D:    k = '{hit: 1'b1, dir: DIR_RIGHT};
            default: k = '0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/ps2_dir_decoder_if.sv
// Byte-input / turn-request bus between the PS/2 receiver, the decoder and the location controller.
interface ps2_dir_decoder_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       req_ack;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic       req_valid;
    logic [1:0] req_dir;

    modport master (
        output byte_valid, byte_data, req_ack,
        input  up, down, left, right, req_valid, req_dir
    );

    modport slave (
        input  byte_valid, byte_data, req_ack,
        output up, down, left, right, req_valid, req_dir
    );
endinterface

// File: rtl/ps2_prefix_tracker.sv
// E0/F0 prefix FSM with idle timeout; emits a combinational one-cycle code strobe
// tagged with the extended/break flags of the prefix that preceded it.
module ps2_prefix_tracker
    import pacman_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       byte_valid_i,
    input  logic [7:0] byte_data_i,
    output logic       code_valid_o,
    output logic [7:0] code_o,
    output logic       is_ext_o,
    output logic       is_break_o
);

    localparam int unsigned CNT_W =
        ($clog2(TIMEOUT_CYCLES + 1) > 17) ? $clog2(TIMEOUT_CYCLES + 1) : 17;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    prefix_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= PS_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A byte arriving in the same cycle as the timeout wins; it is parsed with the live prefix.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (byte_valid_i) begin
            cnt_d = '0;
            case (state_q)
                PS_IDLE: begin
                    if (byte_data_i == SC_EXT)      state_d = PS_EXT;
                    else if (byte_data_i == SC_BRK) state_d = PS_BRK;
                end
                PS_EXT: begin
                    if (byte_data_i == SC_BRK)      state_d = PS_EXT_BRK;
                    else if (byte_data_i != SC_EXT) state_d = PS_IDLE;
                end
                default: state_d = PS_IDLE;
            endcase
        end else if (state_q != PS_IDLE) begin
            if (cnt_q == CNT_LAST) begin
                state_d = PS_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        code_valid_o = 1'b0;
        is_ext_o     = 1'b0;
        is_break_o   = 1'b0;
        code_o       = byte_data_i;
        if (byte_valid_i) begin
            case (state_q)
                PS_IDLE: begin
                    code_valid_o = (byte_data_i != SC_EXT) && (byte_data_i != SC_BRK);
                end
                PS_EXT: begin
                    code_valid_o = (byte_data_i != SC_EXT) && (byte_data_i != SC_BRK);
                    is_ext_o     = 1'b1;
                end
                PS_BRK: begin
                    code_valid_o = 1'b1;
                    is_break_o   = 1'b1;
                end
                PS_EXT_BRK: begin
                    code_valid_o = 1'b1;
                    is_ext_o     = 1'b1;
                    is_break_o   = 1'b1;
                end
                default: code_valid_o = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/ps2_dir_decoder.sv
// PS/2 arrow-key direction decoder: held mask, last-press priority and turn request.
// Define PS2_WASD_EN to also decode non-extended W/A/S/D onto the same directions.
module ps2_dir_decoder
    import pacman_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    ps2_dir_decoder_if.slave  bus
);

    logic       code_valid;
    logic [7:0] code;
    logic       is_ext;
    logic       is_break;

    ps2_prefix_tracker #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_prefix (
        .clk_i        (CLOCK_50),
        .rst_i        (reset),
        .byte_valid_i (bus.byte_valid),
        .byte_data_i  (bus.byte_data),
        .code_valid_o (code_valid),
        .code_o       (code),
        .is_ext_o     (is_ext),
        .is_break_o   (is_break)
    );

    key_hit_t key;

    always_comb begin
        key = '0;
        if (code_valid) begin
            if (is_ext) begin
                key = arrow_lookup(code);
            end
`ifdef PS2_WASD_EN
            else begin
                key = wasd_lookup(code);
            end
`endif
        end
    end

    logic [3:0] held_q, held_d;
    dir_t       last_q, last_d;
    logic       req_valid_q, req_valid_d;
    dir_t       req_dir_q, req_dir_d;
    logic [3:0] dir_oh_q, dir_oh_d;
    logic       press;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            held_q      <= '0;
            last_q      <= DIR_UP;
            req_valid_q <= 1'b0;
            req_dir_q   <= DIR_UP;
            dir_oh_q    <= '0;
        end else begin
            held_q      <= held_d;
            last_q      <= last_d;
            req_valid_q <= req_valid_d;
            req_dir_q   <= req_dir_d;
            dir_oh_q    <= dir_oh_d;
        end
    end

    always_comb begin
        held_d      = held_q;
        last_d      = last_q;
        req_valid_d = req_valid_q;
        req_dir_d   = req_dir_q;
        press       = 1'b0;

        if (key.hit) begin
            if (is_break) begin
                held_d[key.dir] = 1'b0;
            end else if (!held_q[key.dir]) begin
                held_d[key.dir] = 1'b1;
                last_d          = key.dir;
                press           = 1'b1;
            end
        end

        // A press coinciding with the ack re-arms the request with the new direction.
        if (bus.req_ack && req_valid_q) req_valid_d = 1'b0;
        if (press) begin
            req_valid_d = 1'b1;
            req_dir_d   = key.dir;
        end

        dir_oh_d = '0;
        if (held_d[last_d]) begin
            dir_oh_d[last_d] = 1'b1;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (held_d[i[1:0]] && (dir_oh_d == '0)) dir_oh_d[i[1:0]] = 1'b1;
            end
        end
    end

    assign bus.up        = dir_oh_q[DIR_UP];
    assign bus.down      = dir_oh_q[DIR_DOWN];
    assign bus.left      = dir_oh_q[DIR_LEFT];
    assign bus.right     = dir_oh_q[DIR_RIGHT];
    assign bus.req_valid = req_valid_q;
    assign bus.req_dir   = req_dir_q;

endmodule

// File: tb/tb_ps2_dir_decoder.sv
// Randomized and directed bench for ps2_dir_decoder against a byte-level behavioural model.
module tb_ps2_dir_decoder;

    localparam int TO = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_dir_decoder_if bus();

    ps2_dir_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model: held keys by direction index, last press, request, pending prefix flags.
    bit [3:0] m_held;
    int       m_last;
    bit       m_rv;
    int       m_rdir;
    bit       m_ext, m_brk;
    longint   cyc, last_byte_cyc;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_map(input bit ext, input logic [7:0] c, output int d);
        d = 0;
        if (ext) begin
            case (c)
                8'h75: begin d = 0; return 1; end
                8'h72: begin d = 1; return 1; end
                8'h6B: begin d = 2; return 1; end
                8'h74: begin d = 3; return 1; end
                default: return 0;
            endcase
        end
`ifdef PS2_WASD_EN
        case (c)
            8'h1D: begin d = 0; return 1; end
            8'h1B: begin d = 1; return 1; end
            8'h1C: begin d = 2; return 1; end
            8'h23: begin d = 3; return 1; end
            default: return 0;
        endcase
`else
        return 0;
`endif
    endfunction

    // Expected {up,down,left,right}
    function automatic logic [3:0] m_dirs();
        int s = -1;
        logic [3:0] r = '0;
        if (m_held[m_last]) s = m_last;
        else for (int i = 0; i < 4; i++) if (m_held[i] && s < 0) s = i;
        if (s >= 0) r[3 - s] = 1'b1;
        return r;
    endfunction

    function automatic void m_reset();
        m_held = '0; m_last = 0; m_rv = 0; m_rdir = 0;
        m_ext = 0; m_brk = 0;
    endfunction

    function automatic void m_update(input bit bv, input logic [7:0] b, input bit ack);
        bit press = 0;
        int d = 0;
        if (bv) begin
            if ((m_ext || m_brk) && (cyc - last_byte_cyc - 1 >= TO)) begin
                m_ext = 0; m_brk = 0;
            end
            last_byte_cyc = cyc;
            if (m_brk) begin
                if (m_map(m_ext, b, d)) m_held[d] = 0;
                m_ext = 0; m_brk = 0;
            end else if (m_ext && b == 8'hF0) begin
                m_brk = 1;
            end else if (!m_ext && b == 8'hE0) begin
                m_ext = 1;
            end else if (!m_ext && b == 8'hF0) begin
                m_brk = 1;
            end else if (!(m_ext && b == 8'hE0)) begin
                if (m_map(m_ext, b, d) && !m_held[d]) begin
                    m_held[d] = 1; m_last = d; press = 1;
                end
                m_ext = 0;
            end
        end
        if (ack && m_rv) m_rv = 0;
        if (press) begin m_rv = 1; m_rdir = d; end
    endfunction

    task automatic step(input bit bv, input logic [7:0] b, input bit ack);
        @(negedge clk);
        bus.byte_valid = bv;
        bus.byte_data  = b;
        bus.req_ack    = ack;
        @(posedge clk);
        m_update(bv, b, ack);
        #1;
        chk("dirs", {4'h0, bus.up, bus.down, bus.left, bus.right}, {4'h0, m_dirs()});
        chk("req_valid", {7'h0, bus.req_valid}, {7'h0, m_rv});
        chk("req_dir", {6'h0, bus.req_dir}, 8'(m_rdir));
        cyc++;
    endtask

    task automatic send(input logic [7:0] b, input bit ack = 0);
        step(1, b, ack);
    endtask

    task automatic gap(input int n, input bit rnd_ack = 0);
        for (int i = 0; i < n; i++) step(0, 8'h00, rnd_ack && ($urandom_range(0, 3) == 0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.byte_valid = 1'b0; bus.byte_data = 8'h00; bus.req_ack = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_dirs", {4'h0, bus.up, bus.down, bus.left, bus.right}, 8'h00);
        chk("rst_req_valid", {7'h0, bus.req_valid}, 8'h00);
        chk("rst_req_dir", {6'h0, bus.req_dir}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        cyc++;
        last_byte_cyc = cyc;
    endtask

    task automatic press_ext(input logic [7:0] c, input bit ack = 0);
        send(8'hE0); send(c, ack);
    endtask

    task automatic release_ext(input logic [7:0] c);
        send(8'hE0); send(8'hF0); send(c);
    endtask

    logic [7:0] pool [8] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h1D, 8'h1B, 8'h1C, 8'h23};

    initial begin
        bus.byte_valid = 1'b0; bus.byte_data = 8'h00; bus.req_ack = 1'b0;
        cyc = 0; last_byte_cyc = 0;
        m_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Press and release up.
        press_ext(8'h75);
        chk("r29_up", {7'h0, bus.up}, 8'h01);
        chk("r29_rv", {7'h0, bus.req_valid}, 8'h01);
        chk("r29_rdir", {6'h0, bus.req_dir}, 8'h00);
        release_ext(8'h75);
        chk("r29_rel_up", {7'h0, bus.up}, 8'h00);
        chk("r29_rel_rv", {7'h0, bus.req_valid}, 8'h01);
        step(0, 8'h00, 1);
        chk("ack_clears", {7'h0, bus.req_valid}, 8'h00);

        // Two held keys, newest wins, release falls back.
        press_ext(8'h6B);
        press_ext(8'h74);
        chk("r30_right", {7'h0, bus.right}, 8'h01);
        chk("r30_rdir", {6'h0, bus.req_dir}, 8'h03);
        release_ext(8'h74);
        chk("r30_left", {7'h0, bus.left}, 8'h01);
        chk("r30_rdir_kept", {6'h0, bus.req_dir}, 8'h03);
        release_ext(8'h6B);
        step(0, 8'h00, 1);

        // Typematic repeats after an ack raise nothing.
        press_ext(8'h75);
        step(0, 8'h00, 1);
        for (int i = 0; i < 4; i++) press_ext(8'h75);
        chk("r31_rv", {7'h0, bus.req_valid}, 8'h00);
        chk("r31_up", {7'h0, bus.up}, 8'h01);
        release_ext(8'h75);

        // New press completing together with the ack of a pending up.
        press_ext(8'h75);
        press_ext(8'h72, 1);
        chk("r33_rv", {7'h0, bus.req_valid}, 8'h01);
        chk("r33_rdir", {6'h0, bus.req_dir}, 8'h01);
        chk("r33_down", {7'h0, bus.down}, 8'h01);
        release_ext(8'h72);
        release_ext(8'h75);
        step(0, 8'h00, 1);

        // Prefix timeout, then just inside the limit.
        send(8'hE0); gap(TO + 3); send(8'h75);
        chk("r32_up", {7'h0, bus.up}, 8'h00);
        chk("r32_rv", {7'h0, bus.req_valid}, 8'h00);
        send(8'hE0); gap(TO - 3); send(8'h75);
        chk("r32_in_up", {7'h0, bus.up}, 8'h01);
        chk("r32_in_rv", {7'h0, bus.req_valid}, 8'h01);
        release_ext(8'h75);
        step(0, 8'h00, 1);

        // WASD and reset mid-prefix.
        do_reset();
        send(8'h1D);
`ifdef PS2_WASD_EN
        chk("r34_w_up", {7'h0, bus.up}, 8'h01);
        chk("r34_w_rv", {7'h0, bus.req_valid}, 8'h01);
        chk("r34_w_rdir", {6'h0, bus.req_dir}, 8'h00);
`else
        chk("r34_w_dirs", {4'h0, bus.up, bus.down, bus.left, bus.right}, 8'h00);
        chk("r34_w_rv", {7'h0, bus.req_valid}, 8'h00);
`endif
        do_reset();
        send(8'hE0);
        do_reset();
        send(8'h75);
        chk("r34_rst_up", {7'h0, bus.up}, 8'h00);
        chk("r34_rst_rv", {7'h0, bus.req_valid}, 8'h00);

        // Random byte streams with random acks.
        for (int it = 0; it < 400; it++) begin
            int r = $urandom_range(0, 9);
            logic [7:0] code = (r < 8) ? pool[r] : 8'($urandom_range(0, 255));
            bit ext = ($urandom_range(0, 3) != 0);
            bit brk = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 59) == 0) do_reset();
            if (ext) begin
                send(8'hE0, $urandom_range(0, 3) == 0);
                if ($urandom_range(0, 9) == 0) send(8'hE0);
                gap($urandom_range(0, 2), 1);
            end
            if (brk) begin
                send(8'hF0, $urandom_range(0, 3) == 0);
                gap($urandom_range(0, 2), 1);
            end
            if ((ext || brk) && $urandom_range(0, 29) == 0) gap(TO + 5, 1);
            send(code, $urandom_range(0, 3) == 0);
            gap($urandom_range(0, 2), 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ps2_dir_decoder.md
PS2_DIR_DECODER -- requirements
Module: ps2_dir_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000 (1 ms at 50 MHz): idle cycles after a prefix byte before the prefix is abandoned.
REQ-002 CLOCK_50  input  1  system clock; the block's only clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 byte_valid  input  1  one-cycle strobe, byte_data holds a complete PS/2 set-2 byte.
REQ-005 byte_data  input  8  received scan-code byte.
REQ-006 req_ack  input  1  consumer (pacman location controller) accepts the pending turn request; pulsed with its move-done.
REQ-007 up, down, left, right  output  1 each  held-direction levels, at most one high.
REQ-008 req_valid  output  1  a new-press turn request is pending.
REQ-009 req_dir  output  2  pending request direction (dir_t encoding).

Function
REQ-010 Prefix FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen); transitions only on byte_valid, except the timeout in REQ-015.
REQ-011 IDLE: E0 -> EXT; F0 -> BRK; any other byte = non-extended make, stay IDLE.
REQ-012 EXT: F0 -> EXT_BRK; E0 -> stay EXT; other byte = extended make -> IDLE.
REQ-013 BRK: any byte = non-extended break -> IDLE; EXT_BRK: any byte = extended break -> IDLE.
REQ-014 Extended direction codes: 75 up, 72 down, 6B left, 74 right; all other codes are consumed with no effect on held mask or request.
REQ-015 A 17-bit-or-wider idle counter runs in any non-IDLE state, clears on byte_valid; at TIMEOUT_CYCLES it forces IDLE with no key effect.
REQ-016 Held mask [3:0]: make sets bit, break clears bit; break of an unheld key has no effect.
REQ-017 Make of a key not already held = new press: loads last_dir, sets req_valid, loads req_dir; newest press overwrites a pending request.
REQ-018 Typematic repeat (make of held key) changes nothing and raises no request.
REQ-019 Direction outputs: last_dir if its held bit set, else lowest-index held bit (up>down>left>right), else all low.
REQ-020 req_ack with req_valid clears req_valid next cycle; req_ack without req_valid ignored.
REQ-021 New press in the same cycle as req_ack: request remains valid with the new direction.
REQ-022 All outputs registered; effect of the completing byte visible one cycle after its byte_valid.

Reset
REQ-023 Reset forces IDLE, held mask 0, last_dir DIR_UP, req_valid 0, req_dir 0, up/down/left/right 0, idle counter 0.
REQ-024 Reset asserted mid-sequence (e.g. after E0) discards the prefix; the first byte after release is parsed from IDLE.

Configuration
REQ-025 Macro PS2_WASD_EN defined: non-extended codes 1D/1B/1C/23 map to up/down/left/right with the same make/break/request rules as arrows, sharing the same held bits.
REQ-026 PS2_WASD_EN undefined: non-extended codes never affect state; only arrow keys are decoded.

Structure
REQ-027 Shared package pacman_pkg holds dir_t (DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3), the prefix-state enum and all scan-code constants (E0, F0, arrow and WASD codes).
REQ-028 Sub-module ps2_prefix_tracker holds the prefix FSM and timeout counter, outputting a one-cycle code strobe with is_ext and is_break flags; ps2_dir_decoder holds the mask, priority and request logic.

Verification
REQ-029 Bytes E0,75 -> next cycle up=1, req_valid=1, req_dir=0; then E0,F0,75 -> up=0, req_valid still 1.
REQ-030 Press E0,6B then E0,74 with no ack -> right=1, req_dir=3; release right -> left=1, no new request.
REQ-031 E0,75 repeated 5 times, ack after first -> req_valid clears, stays 0 for the repeats.
REQ-032 E0 then no byte for TIMEOUT_CYCLES, then 75 -> no direction change, req_valid=0.
REQ-033 New press E0,72 completes in the same cycle as req_ack of a pending up -> req_valid=1, req_dir=1.
REQ-034 Byte 1D with PS2_WASD_EN defined -> up=1, req_dir=0; without the macro -> all outputs stay 0; reset after E0 followed by 75 -> no effect.
